// File: rtl/jfpjc_pkg.sv
// Shared definitions for the JPEG front-end pipeline: strip geometry and
// the strip scheduler state encoding.
package jfpjc_pkg;

    localparam int unsigned STRIP_ROWS = 8;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_RUN   = 2'd1,
        SCHED_DRAIN = 2'd2
    } sched_state_t;

    // Index width for a strip counter; never zero even for single-strip frames.
    function automatic int unsigned index_width(input int unsigned strips);
        return (strips > 1) ? $clog2(strips) : 1;
    endfunction

endpackage

// File: rtl/hm01b0_strip_scheduler_if.sv
// Event/handshake bundle between the HM01B0 ingester, the strip scheduler
// and the JPEG compressor front end.
interface hm01b0_strip_scheduler_if
    import jfpjc_pkg::*;
#(
    parameter int unsigned height_pix = 240
);
    localparam int unsigned index_w = index_width(height_pix / STRIP_ROWS);

    logic               frame_start;
    logic               strip_written;
    logic               strip_consumed;
    logic               frontbuffer_select;
    logic               compress_buffer;
    logic               compress_start;
    logic               ingest_enable;
    logic [index_w-1:0] strip_index;
    logic               frame_done;
    logic               frame_abort;
    logic               overrun;
    logic [7:0]         dropped_count;

    // Ingester/compressor side.
    modport master (
        output frame_start, strip_written, strip_consumed,
        input  frontbuffer_select, compress_buffer, compress_start,
               ingest_enable, strip_index, frame_done, frame_abort,
               overrun, dropped_count
    );

    // Scheduler side.
    modport slave (
        input  frame_start, strip_written, strip_consumed,
        output frontbuffer_select, compress_buffer, compress_start,
               ingest_enable, strip_index, frame_done, frame_abort,
               overrun, dropped_count
    );

endinterface

// File: rtl/hm01b0_strip_scheduler.sv
// Ping-pong strip buffer scheduler: hands completed 8-row strips from the
// camera ingester to the compressor and flags strips lost to overrun.
module hm01b0_strip_scheduler
    import jfpjc_pkg::*;
#(
    parameter int unsigned width_pix  = 320,
    parameter int unsigned height_pix = 240
) (
    input  logic                     clock,
    input  logic                     reset,
    hm01b0_strip_scheduler_if.slave  bus
);

    localparam int unsigned strips_per_frame = height_pix / STRIP_ROWS;
    localparam int unsigned index_w          = index_width(strips_per_frame);
    localparam logic [index_w-1:0] last_index = index_w'(strips_per_frame - 1);

    if ((width_pix % STRIP_ROWS) != 0) begin : g_bad_width
        $error("hm01b0_strip_scheduler: width_pix must be a multiple of 8");
    end
    if ((height_pix % STRIP_ROWS) != 0) begin : g_bad_height
        $error("hm01b0_strip_scheduler: height_pix must be a multiple of 8");
    end

    sched_state_t       state_q, state_nxt;
    logic               front_q, front_nxt;
    logic               cbuf_q, cbuf_nxt;
    logic               busy_q, busy_nxt;
    logic               start_q, start_nxt;
    logic               ingest_q, ingest_nxt;
    logic [index_w-1:0] index_q, index_nxt;
    logic               done_q, done_nxt;
    logic               abort_q, abort_nxt;
    logic               overrun_q, overrun_nxt;
    logic [7:0]         dropped_q, dropped_nxt;

    // The compressor can take a new strip if idle or releasing this cycle.
    logic comp_free;
    assign comp_free = !busy_q || bus.strip_consumed;

    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_nxt   = state_q;
        front_nxt   = front_q;
        cbuf_nxt    = cbuf_q;
        busy_nxt    = busy_q;
        index_nxt   = index_q;
        overrun_nxt = overrun_q;
        dropped_nxt = dropped_q;
        start_nxt   = 1'b0;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;

        if (bus.strip_consumed) begin
            busy_nxt = 1'b0;
        end

        if (bus.frame_start) begin
            // Buffer selects and comp_busy survive a restart on purpose.
            abort_nxt   = (state_q != SCHED_IDLE);
            state_nxt   = SCHED_RUN;
            index_nxt   = '0;
            overrun_nxt = 1'b0;
            dropped_nxt = '0;
        end else begin
            unique case (state_q)
                SCHED_RUN: begin
                    if (bus.strip_written) begin
                        if (comp_free) begin
                            cbuf_nxt  = front_q;
                            front_nxt = !front_q;
                            busy_nxt  = 1'b1;
                            start_nxt = 1'b1;
                        end else begin
                            overrun_nxt = 1'b1;
                            if (dropped_q != 8'hFF) begin
                                dropped_nxt = dropped_q + 8'd1;
                            end
                        end
                        if (index_q == last_index) begin
                            state_nxt = SCHED_DRAIN;
                        end else begin
                            index_nxt = index_q + 1'b1;
                        end
                    end
                end
                SCHED_DRAIN: begin
                    if (comp_free) begin
                        done_nxt  = 1'b1;
                        state_nxt = SCHED_IDLE;
                    end
                end
                default: ;
            endcase
        end

        ingest_nxt = (state_nxt == SCHED_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= SCHED_IDLE;
            front_q   <= 1'b0;
            cbuf_q    <= 1'b1;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            ingest_q  <= 1'b0;
            index_q   <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_nxt;
            front_q   <= front_nxt;
            cbuf_q    <= cbuf_nxt;
            busy_q    <= busy_nxt;
            start_q   <= start_nxt;
            ingest_q  <= ingest_nxt;
            index_q   <= index_nxt;
            done_q    <= done_nxt;
            abort_q   <= abort_nxt;
            overrun_q <= overrun_nxt;
            dropped_q <= dropped_nxt;
        end
    end

    assign bus.frontbuffer_select = front_q;
    assign bus.compress_buffer    = cbuf_q;
    assign bus.compress_start     = start_q;
    assign bus.ingest_enable      = ingest_q;
    assign bus.strip_index        = index_q;
    assign bus.frame_done         = done_q;
    assign bus.frame_abort        = abort_q;
    assign bus.overrun            = overrun_q;
    assign bus.dropped_count      = dropped_q;

endmodule

// File: tb/tb_hm01b0_strip_scheduler.sv
// Directed bench for the strip scheduler with a 4-strip (32-row) frame.
module tb_hm01b0_strip_scheduler;

    localparam int unsigned height = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    hm01b0_strip_scheduler_if #(.height_pix(height)) bus ();

    hm01b0_strip_scheduler #(
        .width_pix  (320),
        .height_pix (height)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given input pulses; returns just after the edge.
    task automatic step(input logic fs, input logic sw, input logic sc);
        @(negedge clock);
        bus.frame_start    = fs;
        bus.strip_written  = sw;
        bus.strip_consumed = sc;
        @(posedge clock);
        #1;
        bus.frame_start    = 1'b0;
        bus.strip_written  = 1'b0;
        bus.strip_consumed = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_front"},   32'(bus.frontbuffer_select), 0);
        check({tag, "_cbuf"},    32'(bus.compress_buffer),    1);
        check({tag, "_start"},   32'(bus.compress_start),     0);
        check({tag, "_ingest"},  32'(bus.ingest_enable),      0);
        check({tag, "_index"},   32'(bus.strip_index),        0);
        check({tag, "_done"},    32'(bus.frame_done),         0);
        check({tag, "_abort"},   32'(bus.frame_abort),        0);
        check({tag, "_overrun"}, 32'(bus.overrun),            0);
        check({tag, "_dropped"}, 32'(bus.dropped_count),      0);
    endtask

    initial begin
        bus.frame_start    = 1'b0;
        bus.strip_written  = 1'b0;
        bus.strip_consumed = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b0;

        // Clean frame: four strips, each consumed 20 cycles after writing.
        step(1, 0, 0);
        check("clean_ingest", 32'(bus.ingest_enable), 1);
        check("clean_abort",  32'(bus.frame_abort),   0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0);
            check($sformatf("clean_start%0d", k), 32'(bus.compress_start),     1);
            check($sformatf("clean_cbuf%0d", k),  32'(bus.compress_buffer),    k % 2);
            check($sformatf("clean_front%0d", k), 32'(bus.frontbuffer_select), (k + 1) % 2);
            check($sformatf("clean_index%0d", k), 32'(bus.strip_index),        (k < 3) ? k + 1 : 3);
            check($sformatf("clean_ingest%0d", k), 32'(bus.ingest_enable),     (k < 3) ? 1 : 0);
            repeat (19) step(0, 0, 0);
            step(0, 0, 1);
            check($sformatf("clean_done%0d", k), 32'(bus.frame_done), (k == 3) ? 1 : 0);
        end
        step(0, 0, 0);
        check("clean_done_low", 32'(bus.frame_done), 0);
        check("clean_overrun",  32'(bus.overrun),    0);
        check("clean_done_cnt", 32'(done_cnt),       1);

        // Overrun: second strip while the first is still held.
        step(1, 0, 0);
        step(0, 1, 0);
        check("ovr_cbuf0",  32'(bus.compress_buffer),    0);
        check("ovr_front0", 32'(bus.frontbuffer_select), 1);
        step(0, 1, 0);
        check("ovr_start",   32'(bus.compress_start),     0);
        check("ovr_front",   32'(bus.frontbuffer_select), 1);
        check("ovr_cbuf",    32'(bus.compress_buffer),    0);
        check("ovr_flag",    32'(bus.overrun),            1);
        check("ovr_dropped", 32'(bus.dropped_count),      1);
        check("ovr_index",   32'(bus.strip_index),        2);

        // Mid-frame restart at strip 2; compressor stays busy.
        step(1, 0, 0);
        check("abort_pulse",   32'(bus.frame_abort),        1);
        check("abort_index",   32'(bus.strip_index),        0);
        check("abort_overrun", 32'(bus.overrun),            0);
        check("abort_dropped", 32'(bus.dropped_count),      0);
        check("abort_front",   32'(bus.frontbuffer_select), 1);
        check("abort_cbuf",    32'(bus.compress_buffer),    0);
        check("abort_ingest",  32'(bus.ingest_enable),      1);
        step(0, 0, 0);
        check("abort_low", 32'(bus.frame_abort), 0);
        step(0, 1, 0);
        check("busy_kept_start",   32'(bus.compress_start), 0);
        check("busy_kept_overrun", 32'(bus.overrun),        1);

        // Same-cycle write and release after another restart.
        step(1, 0, 0);
        check("abort2_overrun", 32'(bus.overrun), 0);
        step(0, 1, 1);
        check("same_start",   32'(bus.compress_start),     1);
        check("same_cbuf",    32'(bus.compress_buffer),    1);
        check("same_front",   32'(bus.frontbuffer_select), 0);
        check("same_overrun", 32'(bus.overrun),            0);
        check("same_index",   32'(bus.strip_index),        1);

        // Drain: remaining strips all overrun, last one moves to DRAIN.
        step(0, 1, 0);
        step(0, 1, 0);
        check("drain_dropped2", 32'(bus.dropped_count), 2);
        step(0, 1, 0);
        check("drain_dropped3", 32'(bus.dropped_count), 3);
        check("drain_index",    32'(bus.strip_index),   3);
        check("drain_ingest",   32'(bus.ingest_enable), 0);
        step(0, 0, 0);
        check("drain_wait_done", 32'(bus.frame_done), 0);
        step(0, 0, 1);
        check("drain_done", 32'(bus.frame_done), 1);
        step(0, 0, 0);
        check("drain_done_low", 32'(bus.frame_done), 0);
        step(0, 1, 0);
        check("idle_sw_start", 32'(bus.compress_start),     0);
        check("idle_sw_index", 32'(bus.strip_index),        3);
        check("idle_sw_front", 32'(bus.frontbuffer_select), 0);

        // Async reset while draining with the compressor busy.
        step(1, 0, 0);
        step(0, 1, 0);
        check("rd_cbuf", 32'(bus.compress_buffer), 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        check("rd_ingest", 32'(bus.ingest_enable), 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_values("async");
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 1);
        check("spur_start", 32'(bus.compress_start), 0);
        check("spur_done",  32'(bus.frame_done),     0);
        check("spur_cbuf",  32'(bus.compress_buffer), 1);
        step(1, 0, 0);
        check("post_abort", 32'(bus.frame_abort), 0);
        step(0, 1, 0);
        check("post_start",   32'(bus.compress_start),     1);
        check("post_front",   32'(bus.frontbuffer_select), 1);
        check("post_overrun", 32'(bus.overrun),            0);

        // frame_start beats a same-cycle strip_written.
        step(1, 1, 0);
        check("fs_wins_abort", 32'(bus.frame_abort),        1);
        check("fs_wins_index", 32'(bus.strip_index),        0);
        check("fs_wins_start", 32'(bus.compress_start),     0);
        check("fs_wins_front", 32'(bus.frontbuffer_select), 1);

        check("total_done_cnt", 32'(done_cnt), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
